// File: rtl/stream_mux_rr.sv
// Registered N-channel stream multiplexer with valid/ready handshakes.
// Fixed-select or round-robin arbitration feeds a single-entry output register.
module stream_mux_rr #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic            load_en;
  logic            grant_ok;
  logic [SELW-1:0] grant;
  logic [SELW-1:0] rr_idx;
  logic [SELW-1:0] ptr;
  logic [WIDTH-1:0] grant_data;

  // Output register can accept a word when empty or being drained this cycle.
  assign load_en = !out_valid || out_ready;

  // Grant selection: fixed channel, or first valid channel scanning from ptr.
  always_comb begin
    grant    = sel;
    grant_ok = in_valid[sel];
    rr_idx   = ptr;
    if (mode) begin
      grant    = '0;
      grant_ok = 1'b0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        rr_idx = ptr + SELW'(k);
        if (!grant_ok && in_valid[rr_idx]) begin
          grant    = rr_idx;
          grant_ok = 1'b1;
        end
      end
    end
  end

  // One-hot ready on the granted channel; held low while in reset.
  assign in_ready = (!reset && load_en && grant_ok) ? (CHANNELS'(1) << grant) : '0;

  assign grant_data = in_data[grant*WIDTH +: WIDTH];

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load_en) begin
      if (grant_ok) begin
        out_data  <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode) begin
          ptr <= grant + SELW'(1);
        end
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
